// File: rtl/alu_pkg.sv
// Shared definitions for the multi-cycle ALU: op codes, FSM states and the flag bundle.
package alu_pkg;

    localparam logic [3:0] OP_AND    = 4'b0000;
    localparam logic [3:0] OP_OR     = 4'b0001;
    localparam logic [3:0] OP_ADD    = 4'b0010;
    localparam logic [3:0] OP_SUB    = 4'b0110;
    localparam logic [3:0] OP_PASS_B = 4'b0111;
    localparam logic [3:0] OP_NOR    = 4'b1100;
    localparam logic [3:0] OP_LSL    = 4'b1000;
    localparam logic [3:0] OP_LSR    = 4'b1001;
    localparam logic [3:0] OP_MUL    = 4'b1010;

    typedef enum logic [0:0] {
        S_IDLE,
        S_MUL
    } state_e;

    typedef struct packed {
        logic n;
        logic z;
        logic c;
        logic v;
    } flags_t;

endpackage

// File: rtl/alu_mul_iter.sv
// Iterative shift-add multiplier: low WIDTH bits of a*b, done asserted on the WIDTH-th step.
module alu_mul_iter #(
    parameter int unsigned WIDTH = 64
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] product
);

    localparam int unsigned CntW = $clog2(WIDTH);
    localparam logic [CntW-1:0] LastCnt = CntW'(WIDTH - 1);

    logic [WIDTH-1:0] a_q, a_d, b_q, b_d, acc_q, acc_d;
    logic [CntW-1:0]  cnt_q, cnt_d;
    logic             busy_q, busy_d;

    // product already includes the current step so the top can capture it on the final edge
    assign product = acc_q + (b_q[0] ? a_q : '0);
    assign done    = busy_q && (cnt_q == LastCnt);
    assign busy    = busy_q;

    always_comb begin
        a_d    = a_q;
        b_d    = b_q;
        acc_d  = acc_q;
        cnt_d  = cnt_q;
        busy_d = busy_q;
        if (start) begin
            a_d    = a;
            b_d    = b;
            acc_d  = '0;
            cnt_d  = '0;
            busy_d = 1'b1;
        end else if (busy_q) begin
            acc_d = product;
            a_d   = a_q << 1;
            b_d   = b_q >> 1;
            cnt_d = cnt_q + 1'b1;
            if (done) begin
                busy_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            a_q    <= '0;
            b_q    <= '0;
            acc_q  <= '0;
            cnt_q  <= '0;
            busy_q <= 1'b0;
        end else begin
            a_q    <= a_d;
            b_q    <= b_d;
            acc_q  <= acc_d;
            cnt_q  <= cnt_d;
            busy_q <= busy_d;
        end
    end

endmodule

// File: rtl/alu_mc.sv
// Multi-cycle ALU with NZCV flags, valid/ready handshakes and an iterative MUL.
module alu_mc
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH = 64
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [3:0]       op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             z_flag,
    output logic             n_flag,
    output logic             c_flag,
    output logic             v_flag,
    output logic             op_err
);

    localparam int unsigned ShW = $clog2(WIDTH);

    state_e           state_q, state_d;
    logic             out_valid_q, out_valid_d;
    logic [WIDTH-1:0] result_q, result_d;
    flags_t           flags_q, flags_d;
    logic             op_err_q, op_err_d;

    logic             is_sub, accept, mul_start, mul_busy, mul_done;
    logic [WIDTH:0]   sum;
    logic [ShW-1:0]   shamt;
    logic [WIDTH-1:0] res_c, mul_product;
    logic             err_c, c_c, v_c;

    // SUB reuses the adder as a + ~b + 1, so carry-out is the ARM no-borrow flag
    assign is_sub = (op == OP_SUB);
    assign sum    = {1'b0, a} + {1'b0, (is_sub ? ~b : b)} + {{WIDTH{1'b0}}, is_sub};
    assign shamt  = b[ShW-1:0];

    always_comb begin
        res_c = '0;
        err_c = 1'b0;
        c_c   = 1'b0;
        v_c   = 1'b0;
        case (op)
            OP_AND:    res_c = a & b;
            OP_OR:     res_c = a | b;
            OP_ADD: begin
                res_c = sum[WIDTH-1:0];
                c_c   = sum[WIDTH];
                v_c   = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
            end
            OP_SUB: begin
                res_c = sum[WIDTH-1:0];
                c_c   = sum[WIDTH];
                v_c   = (a[WIDTH-1] != b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
            end
            OP_PASS_B: res_c = b;
            OP_NOR:    res_c = ~(a | b);
            OP_LSL:    res_c = a << shamt;
            OP_LSR:    res_c = a >> shamt;
            OP_MUL:    res_c = '0;
            default:   err_c = 1'b1;
        endcase
    end

    assign in_ready  = (state_q == S_IDLE) && !mul_busy && (!out_valid_q || out_ready);
    assign accept    = in_valid && in_ready;
    assign mul_start = accept && (op == OP_MUL);

    alu_mul_iter #(
        .WIDTH (WIDTH)
    ) u_mul (
        .clk     (clk),
        .reset   (reset),
        .start   (mul_start),
        .a       (a),
        .b       (b),
        .busy    (mul_busy),
        .done    (mul_done),
        .product (mul_product)
    );

    always_comb begin
        state_d     = state_q;
        out_valid_d = out_valid_q;
        result_d    = result_q;
        flags_d     = flags_q;
        op_err_d    = op_err_q;
        if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
        end
        case (state_q)
            S_IDLE: begin
                if (mul_start) begin
                    state_d = S_MUL;
                end else if (accept) begin
                    out_valid_d = 1'b1;
                    result_d    = res_c;
                    flags_d     = '{n: res_c[WIDTH-1], z: (res_c == '0), c: c_c, v: v_c};
                    op_err_d    = err_c;
                end
            end
            S_MUL: begin
                if (mul_done) begin
                    state_d     = S_IDLE;
                    out_valid_d = 1'b1;
                    result_d    = mul_product;
                    flags_d     = '{n: mul_product[WIDTH-1], z: (mul_product == '0),
                                    c: 1'b0, v: 1'b0};
                    op_err_d    = 1'b0;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_IDLE;
            out_valid_q <= 1'b0;
            result_q    <= '0;
            flags_q     <= '0;
            op_err_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            out_valid_q <= out_valid_d;
            result_q    <= result_d;
            flags_q     <= flags_d;
            op_err_q    <= op_err_d;
        end
    end

    assign out_valid = out_valid_q;
    assign result    = result_q;
    assign n_flag    = flags_q.n;
    assign z_flag    = flags_q.z;
    assign c_flag    = flags_q.c;
    assign v_flag    = flags_q.v;
    assign op_err    = op_err_q;

endmodule
